// File: rtl/mux_recirculacion.sv
`default_nettype none
// ============================================================================
// Module   : mux_recirculacion
// Function : Buffers four recirculated lanes in per-lane FIFOs and merges them
//            round-robin onto one registered byte stream; drives IDLE_OUT.
// Revision : 1.0 - initial release
// ============================================================================
module mux_recirculacion #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 3,
  parameter int IDLE_GAP   = 2
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_0rp,
  input  logic [DATA_W-1:0] data_1rp,
  input  logic [DATA_W-1:0] data_2rp,
  input  logic [DATA_W-1:0] data_3rp,
  input  logic              valid_0rp,
  input  logic              valid_1rp,
  input  logic              valid_2rp,
  input  logic              valid_3rp,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_out,
  output logic              pause_0,
  output logic              pause_1,
  output logic              pause_2,
  output logic              pause_3,
  output logic              idle_out,
  output logic              overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int QW    = $clog2(IDLE_GAP + 1);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_AF   = CNT_W'(AF_THRESH);
  localparam logic [QW-1:0]    C_GAP  = QW'(IDLE_GAP);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [DATA_W-1:0] w_din  [4];
  logic [DATA_W-1:0] w_head [4];
  logic [3:0]        w_wr;
  logic [3:0]        w_empty;
  logic [3:0]        w_full;
  logic [3:0]        w_af;
  logic [3:0]        w_push;
  logic [3:0]        w_pop;
  logic [3:0]        w_ovf;

  logic [1:0]        r_rr;
  logic [1:0]        w_sel;
  logic [1:0]        w_idx;
  logic              w_any;
  logic              w_load;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [QW-1:0]     r_quiet;
  logic [QW-1:0]     w_quiet_nxt;
  logic              w_quiet_cond;

  assign w_din[0] = data_0rp;
  assign w_din[1] = data_1rp;
  assign w_din[2] = data_2rp;
  assign w_din[3] = data_3rp;
  assign w_wr     = {valid_3rp, valid_2rp, valid_1rp, valid_0rp};

  // Per-lane FIFO; a pop from a full FIFO frees the slot for a same-cycle push.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  r_wptr;
      logic [PTR_W-1:0]  r_rptr;
      logic [CNT_W-1:0]  r_count;

      assign w_empty[g] = (r_count == '0);
      assign w_full[g]  = (r_count == C_FULL);
      assign w_af[g]    = (r_count >= C_AF);
      assign w_push[g]  = w_wr[g] && (!w_full[g] || w_pop[g]);
      assign w_ovf[g]   = w_wr[g] && w_full[g] && !w_pop[g];
      assign w_head[g]  = r_mem[r_rptr];

      always_ff @(posedge clk_f) begin
        if (!reset && w_push[g]) begin
          r_mem[r_wptr] <= w_din[g];
        end
      end

      always_ff @(posedge clk_f) begin
        if (reset) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[g]) r_wptr <= r_wptr + PTR_W'(1);
          if (w_pop[g])  r_rptr <= r_rptr + PTR_W'(1);
          case ({w_push[g], w_pop[g]})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Search rr+1 .. rr+4; iterating downward lets the nearest lane win.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_rr;
    w_idx = '0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_rr + 2'(k);
      if (!w_empty[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_load = out_ready || !valid_out;
  assign w_pop  = (w_load && w_any) ? (4'b0001 << w_sel) : 4'b0000;

  always_ff @(posedge clk_f) begin
    if (reset) begin
      data_out     <= '0;
      valid_out    <= 1'b0;
      lane_out     <= '0;
      r_rr         <= 2'd3;
      overflow_err <= 1'b0;
    end else begin
      if (|w_ovf) overflow_err <= 1'b1;
      if (w_load) begin
        if (w_any) begin
          data_out  <= w_head[w_sel];
          lane_out  <= w_sel;
          valid_out <= 1'b1;
          r_rr      <= w_sel;
        end else begin
          valid_out <= 1'b0;
        end
      end
    end
  end

  assign w_quiet_cond = (&w_empty) && !valid_out && !(|w_wr);

  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_quiet <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_quiet <= w_quiet_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_quiet_nxt = r_quiet;
    case (r_state)
      ST_IDLE: begin
        w_quiet_nxt = '0;
        if (|w_wr) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_quiet_cond) begin
          if (r_quiet + QW'(1) == C_GAP) begin
            w_state_nxt = ST_IDLE;
            w_quiet_nxt = '0;
          end else begin
            w_quiet_nxt = r_quiet + QW'(1);
          end
        end else begin
          w_quiet_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_quiet_nxt = '0;
      end
    endcase
  end

  assign idle_out = (r_state == ST_IDLE);
  assign pause_0  = w_af[0];
  assign pause_1  = w_af[1];
  assign pause_2  = w_af[2];
  assign pause_3  = w_af[3];

endmodule
`default_nettype wire

// File: tb/tb_mux_recirculacion.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_recirculacion
// Function : Self-checking bench for mux_recirculacion (vector table, per-lane
//            scoreboard and hand-written multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_recirculacion;

  logic             clk_f = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       vrp = '0;
  logic [3:0][7:0]  drp = '0;
  logic             out_ready = 1'b1;
  logic [7:0]       data_out;
  logic             valid_out;
  logic [1:0]       lane_out;
  logic             pause_0, pause_1, pause_2, pause_3;
  logic             idle_out;
  logic             overflow_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]      vmask;
    logic [3:0][7:0] d;
    int              n;
    logic [3:0][1:0] lane;
    logic [3:0][7:0] dat;
  } vec_t;
  vec_t vecs[6];

  always #5 clk_f = ~clk_f;

  mux_recirculacion #(
    .DATA_W(8), .FIFO_DEPTH(4), .AF_THRESH(3), .IDLE_GAP(2)
  ) dut (
    .clk_f(clk_f), .reset(reset),
    .data_0rp(drp[0]), .data_1rp(drp[1]), .data_2rp(drp[2]), .data_3rp(drp[3]),
    .valid_0rp(vrp[0]), .valid_1rp(vrp[1]), .valid_2rp(vrp[2]), .valid_3rp(vrp[3]),
    .out_ready(out_ready),
    .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
    .pause_0(pause_0), .pause_1(pause_1), .pause_2(pause_2), .pause_3(pause_3),
    .idle_out(idle_out), .overflow_err(overflow_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A freshly loaded output byte must match the oldest pending byte of its lane.
  task automatic sb_check();
    int idx;
    idx = -1;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (idx < 0 && sb_q[i].lane == lane_out) idx = i;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got lane %0d data %02h, expected no output", lane_out, data_out);
    end else begin
      chk($sformatf("sb_lane%0d_data", lane_out), 32'(data_out), 32'(sb_q[idx].data));
      sb_q.delete(idx);
    end
  endtask

  task automatic step();
    logic ld;
    ld = out_ready || !valid_out;
    @(posedge clk_f);
    #1;
    if (ld && valid_out && !reset) sb_check();
  endtask

  task automatic wr(input logic [3:0] m, input logic [3:0][7:0] d, input bit push);
    vrp = m;
    drp = d;
    if (push) begin
      for (int l = 0; l < 4; l++) begin
        if (m[l]) sb_q.push_back('{lane: 2'(l), data: d[l]});
      end
    end
    step();
    vrp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vrp = '0;
    step();
    step();
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 10 && !idle_out; t++) step();
    chk(name, 32'(idle_out), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{vmask: 4'b1111, d: {8'h13, 8'h12, 8'h11, 8'h10}, n: 4,
                lane: {2'd3, 2'd2, 2'd1, 2'd0}, dat: {8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[1] = '{vmask: 4'b0100, d: {8'h00, 8'h5C, 8'h00, 8'h00}, n: 1,
                lane: {2'd0, 2'd0, 2'd0, 2'd2}, dat: {8'h00, 8'h00, 8'h00, 8'h5C}};
    vecs[2] = '{vmask: 4'b1111, d: {8'h23, 8'h22, 8'h21, 8'h20}, n: 4,
                lane: {2'd2, 2'd1, 2'd0, 2'd3}, dat: {8'h22, 8'h21, 8'h20, 8'h23}};
    vecs[3] = '{vmask: 4'b0101, d: {8'h00, 8'h32, 8'h00, 8'h30}, n: 2,
                lane: {2'd0, 2'd0, 2'd2, 2'd0}, dat: {8'h00, 8'h00, 8'h32, 8'h30}};
    vecs[4] = '{vmask: 4'b1010, d: {8'h43, 8'h00, 8'h41, 8'h00}, n: 2,
                lane: {2'd0, 2'd0, 2'd1, 2'd3}, dat: {8'h00, 8'h00, 8'h41, 8'h43}};
    vecs[5] = '{vmask: 4'b0010, d: {8'h00, 8'h00, 8'h55, 8'h00}, n: 1,
                lane: {2'd0, 2'd0, 2'd0, 2'd1}, dat: {8'h00, 8'h00, 8'h00, 8'h55}};

    // Reset held with a lane-0 write pending: nothing may be stored.
    reset = 1'b1;
    vrp = 4'b0001;
    drp = {8'h00, 8'h00, 8'h00, 8'hAA};
    step();
    step();
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_lane_out", 32'(lane_out), 32'd0);
    chk("rst_idle_out", 32'(idle_out), 32'd1);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    chk("rst_pause", 32'({pause_3, pause_2, pause_1, pause_0}), 32'd0);
    reset = 1'b0;
    vrp = '0;
    step();
    chk("rst_nostore_0", 32'(valid_out), 32'd0);
    chk("rst_nostore_idle", 32'(idle_out), 32'd1);
    step();
    chk("rst_nostore_1", 32'(valid_out), 32'd0);

    // Single write on lane 2 and the IDLE_GAP return to idle.
    wr(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b1);
    chk("single_idle_drop", 32'(idle_out), 32'd0);
    chk("single_no_bypass", 32'(valid_out), 32'd0);
    step();
    chk("single_valid", 32'(valid_out), 32'd1);
    chk("single_data", 32'(data_out), 32'h5C);
    chk("single_lane", 32'(lane_out), 32'd2);
    step();
    chk("single_valid_clr", 32'(valid_out), 32'd0);
    chk("single_gap0", 32'(idle_out), 32'd0);
    step();
    chk("single_gap1", 32'(idle_out), 32'd0);
    step();
    chk("single_idle_back", 32'(idle_out), 32'd1);

    // Vector table: round-robin order from a known rr, carried across records.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].vmask, vecs[i].d, 1'b1);
      for (int k = 0; k < vecs[i].n; k++) begin
        step();
        chk($sformatf("vec%0d_valid%0d", i, k), 32'(valid_out), 32'd1);
        chk($sformatf("vec%0d_lane%0d", i, k), 32'(lane_out), 32'(vecs[i].lane[k]));
        chk($sformatf("vec%0d_data%0d", i, k), 32'(data_out), 32'(vecs[i].dat[k]));
      end
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // Backpressure: lane 0 byte parks in the stalled output, lane 1 fills up.
    do_reset();
    out_ready = 1'b0;
    wr(4'b0001, {8'h00, 8'h00, 8'h00, 8'hEE}, 1'b1);
    wr(4'b0010, {8'h00, 8'h00, 8'h01, 8'h00}, 1'b1);
    chk("bp_hold_data", 32'(data_out), 32'hEE);
    chk("bp_hold_valid", 32'(valid_out), 32'd1);
    wr(4'b0010, {8'h00, 8'h00, 8'h02, 8'h00}, 1'b1);
    chk("bp_pause_2wr", 32'(pause_1), 32'd0);
    wr(4'b0010, {8'h00, 8'h00, 8'h03, 8'h00}, 1'b1);
    chk("bp_pause_3wr", 32'(pause_1), 32'd1);
    chk("bp_no_ovf_yet", 32'(overflow_err), 32'd0);
    wr(4'b0010, {8'h00, 8'h00, 8'h04, 8'h00}, 1'b1);
    wr(4'b0010, {8'h00, 8'h00, 8'h05, 8'h00}, 1'b0);
    chk("bp_overflow", 32'(overflow_err), 32'd1);
    step();
    step();
    chk("bp_stall_data", 32'(data_out), 32'hEE);
    chk("bp_stall_lane", 32'(lane_out), 32'd0);
    chk("bp_stall_valid", 32'(valid_out), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("bp_out%0d_lane", k), 32'(lane_out), 32'd1);
      chk($sformatf("bp_out%0d_data", k), 32'(data_out), 32'(k + 1));
      if (k == 0) chk("bp_pause_after_pop1", 32'(pause_1), 32'd1);
      if (k == 1) chk("bp_pause_after_pop2", 32'(pause_1), 32'd0);
    end
    step();
    chk("bp_drained", 32'(valid_out), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow_err), 32'd1);

    // Full lane 3: push and pop in the same cycle.
    do_reset();
    out_ready = 1'b0;
    wr(4'b1000, {8'h70, 8'h00, 8'h00, 8'h00}, 1'b1);
    wr(4'b1000, {8'h71, 8'h00, 8'h00, 8'h00}, 1'b1);
    wr(4'b1000, {8'h72, 8'h00, 8'h00, 8'h00}, 1'b1);
    wr(4'b1000, {8'h73, 8'h00, 8'h00, 8'h00}, 1'b1);
    wr(4'b1000, {8'h74, 8'h00, 8'h00, 8'h00}, 1'b1);
    chk("full_pause3", 32'(pause_3), 32'd1);
    chk("full_held", 32'(data_out), 32'h70);
    out_ready = 1'b1;
    wr(4'b1000, {8'h77, 8'h00, 8'h00, 8'h00}, 1'b1);
    chk("full_pp_no_ovf", 32'(overflow_err), 32'd0);
    chk("full_pp_pause3", 32'(pause_3), 32'd1);
    chk("full_pp_data", 32'(data_out), 32'h71);
    begin
      logic [3:0][7:0] exp_seq;
      exp_seq = {8'h77, 8'h74, 8'h73, 8'h72};
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("full_out%0d_data", k), 32'(data_out), 32'(exp_seq[k]));
        chk($sformatf("full_out%0d_lane", k), 32'(lane_out), 32'd3);
      end
    end
    step();
    chk("full_drained", 32'(valid_out), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of draining lanes 0 and 2.
    do_reset();
    out_ready = 1'b0;
    wr(4'b0101, {8'h00, 8'hC0, 8'h00, 8'hA0}, 1'b1);
    wr(4'b0101, {8'h00, 8'hC1, 8'h00, 8'hA1}, 1'b1);
    wr(4'b0101, {8'h00, 8'hC2, 8'h00, 8'hA2}, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_idle", 32'(idle_out), 32'd1);
    reset = 1'b0;
    sb_q.delete();
    for (int t = 0; t < 6; t++) begin
      step();
      chk($sformatf("mid_rst_quiet%0d", t), 32'(valid_out), 32'd0);
    end
    chk("mid_rst_idle_after", 32'(idle_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_recirculacion.md
Name: mux_recirculacion

Overview:
- Transmit-side counterpart of the 4-lane demux/recirculation stage.
- Accepts the four recirculated lanes (data_Xrp/valid_Xrp) and buffers each lane in its own FIFO.
- Merges the lanes round-robin onto a single byte stream under a downstream ready handshake.
- Generates the IDLE_OUT flag that the demux/recirculation stage consumes.

Parameters:
- DATA_W, 8, lane and output byte width.
- FIFO_DEPTH, 4, entries per lane FIFO (power of 2).
- AF_THRESH, 3, per-lane occupancy at or above which pause_X asserts.
- IDLE_GAP, 2, quiet cycles required before returning to IDLE.

Ports:
- clk_f  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_0rp..data_3rp  in  DATA_W  lane bytes from the recirculation path.
- valid_0rp..valid_3rp  in  1  lane write strobes.
- out_ready  in  1  downstream can accept a byte this cycle.
- data_out  out  DATA_W  merged byte, registered.
- valid_out  out  1  data_out is valid, registered.
- lane_out  out  2  source lane of data_out, registered.
- pause_0..pause_3  out  1  lane FIFO occupancy >= AF_THRESH; combinational from counters.
- idle_out  out  1  IDLE_OUT to the demux; 1 while the FSM is in IDLE.
- overflow_err  out  1  sticky: a write hit a full FIFO.

Behaviour:
- Reset (synchronous, sampled at the clk_f edge):
  - All FIFO pointers and counts go to 0; round-robin pointer rr = 3, so lane 0 is served first.
  - data_out = 0, valid_out = 0, lane_out = 0, overflow_err = 0, FSM = IDLE, quiet counter = 0.
  - idle_out = 1; pause_X = 0.
  - Reset asserted mid-operation discards all buffered data in one cycle.
- Lane write:
  - valid_Xrp = 1 and FIFO X not full: the byte is pushed at the edge.
  - FIFO X full: the byte is dropped and overflow_err sets; it clears only on reset.
  - A simultaneous pop from a full FIFO frees a slot, so the push is accepted and the count is unchanged.
- Output stage (single register):
  - Loads when out_ready = 1 or valid_out = 0.
  - On load, the arbiter picks the first non-empty lane searching rr+1, rr+2, rr+3, rr (mod 4).
  - That lane's head is popped into data_out, lane_out is set to the lane, valid_out = 1, and rr becomes the lane.
  - If every lane is empty, valid_out = 0 and data_out/lane_out hold.
  - valid_out = 1 with out_ready = 0: data_out, lane_out and valid_out hold; no pop occurs.
- Latency and ordering:
  - No bypass: a byte written at edge N appears on data_out at the earliest after edge N+1.
  - An empty FIFO cannot be popped in the cycle it is written.
  - Per-lane order is preserved; wrap-around of the FIFO_DEPTH pointers is seamless.
- Counts use log2(FIFO_DEPTH)+1 bits. full: count == FIFO_DEPTH. empty: count == 0.
- FSM:
  - IDLE: idle_out = 1. Go to ACTIVE on any valid_Xrp = 1.
  - ACTIVE: idle_out = 0. The quiet counter increments on cycles with all FIFOs empty, valid_out = 0 and no valid_Xrp; any other cycle clears it.
  - When the quiet counter reaches IDLE_GAP, go to IDLE and clear the counter.
  - Any valid_Xrp in the same cycle the gap completes keeps the FSM in ACTIVE.
- Simultaneous writes on all four lanes are all accepted; the output drains at most one byte per cycle.

Test Plan:
- Reset held for 2 cycles with valid_0rp = 1, data_0rp = 0xAA -> valid_out = 0, data_out = 0x00, idle_out = 1, overflow_err = 0; the byte is not stored.
- Single write, lane 2 = 0x5C with out_ready = 1:
  - Next edge: idle_out = 0.
  - Following edge: data_out = 0x5C, lane_out = 2, valid_out = 1.
  - Then valid_out = 0; idle_out returns to 1 after IDLE_GAP = 2 quiet cycles.
- Same-cycle writes 0x10/0x11/0x12/0x13 on lanes 0-3, out_ready = 1 -> outputs 0x10, 0x11, 0x12, 0x13 with lane_out 0, 1, 2, 3 on consecutive cycles.
- Backpressure: with out_ready = 0, write lane 1 with 0x01..0x04 ->
  - pause_1 = 1 after the 3rd write.
  - A 5th write of 0x05 sets overflow_err.
  - After releasing out_ready: outputs 0x01, 0x02, 0x03, 0x04; the first byte is held stable while stalled.
- Full-lane push/pop: lane 3 full, out_ready = 1, write 0x77 in the same cycle as a pop -> count stays 4, no overflow; 0x77 emerges 4 pops later.
- Reset mid-drain, with 3 bytes queued in lanes 0 and 2 -> next cycle valid_out = 0, idle_out = 1; nothing is emitted afterward without new writes.
